ram_access_arbiter: RTL and testbench

//  Shares the 16x16 dual-port RAM between two requesters (A=0, B=1).

---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 52 +++++
 rtl/ram_access_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared widths, strobe codes and write-FSM encoding for the RAM access arbiter.
package ram_arb_pkg;
    localparam int ADDR_W = 4;
    localparam int HALF_W = 16;
    localparam int NREQ   = 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = 4'd15;

    localparam logic [1:0] STRB_NONE = 2'b00;
    localparam logic [1:0] STRB_LO   = 2'b01;
    localparam logic [1:0] STRB_HI   = 2'b10;
    localparam logic [1:0] STRB_BOTH = 2'b11;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_SPLIT = 1'b1
    } wr_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter with one-hot grant and a registered round-robin pointer.
// Defining RAM_ARB_FIXED_PRIO_EN replaces round-robin with fixed A-over-B priority.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = clk ^ rst_n ^ advance;

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    // ptr_q names the requester that wins a tie (0 = A)
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        ptr_d = ptr_q;
        if (advance && (gnt != 2'b00)) begin
            ptr_d = ~gnt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares a 16x16 dual-port RAM between requesters A and B; a write straddling word 15
// is split so its upper half lands in word 0. RAM_ARB_FIXED_PRIO_EN selects fixed priority.
//
// state   | meaning
// W_IDLE  | accept one write from the arbitration winner
// W_SPLIT | drive the captured upper half to word 0; no write accepted
module ram_access_arbiter
    import ram_arb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            wr_valid,
    output logic [NREQ-1:0]            wr_ready,
    input  logic [NREQ*ADDR_W-1:0]     wr_addr,
    input  logic [NREQ*2-1:0]          wr_strb,
    input  logic [NREQ*2*HALF_W-1:0]   wr_data,
    input  logic [NREQ-1:0]            rd_valid,
    output logic [NREQ-1:0]            rd_ready,
    input  logic [NREQ*ADDR_W-1:0]     rd_addr,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic [HALF_W-1:0]          rsp_data,
    output logic                       ram_wr_en,
    output logic [1:0]                 ram_wr_strb,
    output logic [ADDR_W-1:0]          ram_waddr,
    output logic [2*HALF_W-1:0]        ram_wdata,
    output logic                       ram_rd_en,
    output logic [ADDR_W-1:0]          ram_raddr,
    input  logic [HALF_W-1:0]          ram_rdata
);

    logic [NREQ-1:0]     wr_gnt;
    logic [NREQ-1:0]     rd_gnt;
    logic                wr_hs;
    logic                rd_hs;
    logic                wr_sel;
    logic [ADDR_W-1:0]   sel_waddr;
    logic [1:0]          sel_strb;
    logic [2*HALF_W-1:0] sel_wdata;
    logic [ADDR_W-1:0]   sel_raddr;

    wr_state_e           wr_state_q, wr_state_d;
    logic [HALF_W-1:0]   upper_q, upper_d;
    logic                ram_wr_en_q, ram_wr_en_d;
    logic [1:0]          ram_wr_strb_q, ram_wr_strb_d;
    logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
    logic [2*HALF_W-1:0] ram_wdata_q, ram_wdata_d;
    logic                ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0]   ram_raddr_q, ram_raddr_d;
    logic                rd_id_q, rd_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_id_q, rsp_id_d;

    rr_arb2 u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (wr_valid),
        .advance (wr_hs),
        .gnt     (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rd_valid),
        .advance (rd_hs),
        .gnt     (rd_gnt)
    );

    assign wr_ready  = (wr_state_q == W_IDLE) ? wr_gnt : '0;
    assign wr_hs     = |(wr_valid & wr_ready);
    assign wr_sel    = wr_gnt[1];
    assign sel_waddr = wr_sel ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    assign sel_strb  = wr_sel ? wr_strb[3:2] : wr_strb[1:0];
    assign sel_wdata = wr_sel ? wr_data[4*HALF_W-1:2*HALF_W] : wr_data[2*HALF_W-1:0];

    assign rd_ready  = rd_gnt;
    assign rd_hs     = |(rd_valid & rd_gnt);
    assign sel_raddr = rd_gnt[1] ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];

    // Writes never let the RAM address waddr+1 past word 15.
    always_comb begin
        wr_state_d    = wr_state_q;
        upper_d       = upper_q;
        ram_wr_en_d   = 1'b0;
        ram_wr_strb_d = STRB_NONE;
        ram_waddr_d   = '0;
        ram_wdata_d   = '0;
        case (wr_state_q)
            W_IDLE: begin
                if (wr_hs) begin
                    if ((sel_waddr == LAST_ADDR) && (sel_strb == STRB_BOTH)) begin
                        ram_wr_en_d   = 1'b1;
                        ram_wr_strb_d = STRB_LO;
                        ram_waddr_d   = LAST_ADDR;
                        ram_wdata_d   = {{HALF_W{1'b0}}, sel_wdata[HALF_W-1:0]};
                        upper_d       = sel_wdata[2*HALF_W-1:HALF_W];
                        wr_state_d    = W_SPLIT;
                    end else if ((sel_waddr == LAST_ADDR) && (sel_strb == STRB_HI)) begin
                        ram_wr_en_d   = 1'b1;
                        ram_wr_strb_d = STRB_LO;
                        ram_waddr_d   = '0;
                        ram_wdata_d   = {{HALF_W{1'b0}}, sel_wdata[2*HALF_W-1:HALF_W]};
                    end else if (sel_strb != STRB_NONE) begin
                        ram_wr_en_d   = 1'b1;
                        ram_wr_strb_d = sel_strb;
                        ram_waddr_d   = sel_waddr;
                        ram_wdata_d   = sel_wdata;
                    end
                end
            end
            W_SPLIT: begin
                ram_wr_en_d   = 1'b1;
                ram_wr_strb_d = STRB_LO;
                ram_waddr_d   = '0;
                ram_wdata_d   = {{HALF_W{1'b0}}, upper_q};
                wr_state_d    = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        ram_rd_en_d = rd_hs;
        ram_raddr_d = rd_hs ? sel_raddr : '0;
        rd_id_d     = rd_gnt[1];
        rsp_valid_d = ram_rd_en_q;
        rsp_id_d    = rd_id_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q    <= W_IDLE;
            upper_q       <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_strb_q <= '0;
            ram_waddr_q   <= '0;
            ram_wdata_q   <= '0;
            ram_rd_en_q   <= 1'b0;
            ram_raddr_q   <= '0;
            rd_id_q       <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            upper_q       <= upper_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_strb_q <= ram_wr_strb_d;
            ram_waddr_q   <= ram_waddr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_raddr_q   <= ram_raddr_d;
            rd_id_q       <= rd_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
        end
    end

    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_strb = ram_wr_strb_q;
    assign ram_waddr   = ram_waddr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_raddr   = ram_raddr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    // RAM data arrives in the response cycle itself, so it is passed through, not registered.
    assign rsp_data    = rsp_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 16x16 RAM model.
module tb_ram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wr_valid, wr_ready, rd_valid, rd_ready;
    logic [7:0]  wr_addr, rd_addr;
    logic [3:0]  wr_strb;
    logic [63:0] wr_data;
    logic        rsp_valid, rsp_id;
    logic [15:0] rsp_data;
    logic        ram_wr_en, ram_rd_en;
    logic [1:0]  ram_wr_strb;
    logic [3:0]  ram_waddr, ram_raddr;
    logic [31:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic [15:0] mem [16] = '{default: 16'h0};

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        bit          is_wr;
        logic        id;
        logic [3:0]  addr;
        logic [1:0]  strb;
        logic [31:0] data;
        int          n_beats;
        logic [3:0]  e_addr;
        logic [1:0]  e_strb;
        logic [31:0] e_data;
        logic [15:0] e_rd;
    } cmd_t;

    typedef struct {
        logic [3:0]  addr;
        logic [1:0]  strb;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    beat_t beats[$];
    rsp_t  rsps[$];
    cmd_t  tbl[12];
    logic [1:0] exp_g[4];

    ram_access_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_strb     (wr_strb),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_strb (ram_wr_strb),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .ram_rd_en   (ram_rd_en),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: strb bit0 -> word waddr, bit1 -> word waddr+1; reads return old data.
    always @(posedge clk) begin
        if (ram_wr_en) begin
            if (ram_wr_strb[0]) mem[ram_waddr] <= ram_wdata[15:0];
            if (ram_wr_strb[1]) mem[ram_waddr + 4'd1] <= ram_wdata[31:16];
        end
        if (ram_rd_en) ram_rdata <= mem[ram_raddr];
    end

    always @(negedge clk) begin
        if (ram_wr_en) beats.push_back('{ram_waddr, ram_wr_strb, ram_wdata, cyc});
        if (rsp_valid) rsps.push_back('{rsp_id, rsp_data, cyc});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic cmd_t mk_wr(logic id, logic [3:0] a, logic [1:0] s, logic [31:0] d,
                                   int nb, logic [3:0] ea, logic [1:0] es, logic [31:0] ed);
        cmd_t c;
        c = '{1'b1, id, a, s, d, nb, ea, es, ed, 16'h0};
        return c;
    endfunction

    function automatic cmd_t mk_rd(logic id, logic [3:0] a, logic [15:0] er);
        cmd_t c;
        c = '{1'b0, id, a, 2'b00, 32'h0, 0, 4'h0, 2'b00, 32'h0, er};
        return c;
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({ram_wr_en, ram_wr_strb, ram_waddr, ram_wdata, ram_rd_en, ram_raddr,
                    rsp_valid, rsp_id, rsp_data});
    endfunction

    task automatic set_wr(input logic id, input logic [3:0] a, input logic [1:0] s, input logic [31:0] d);
        if (id) begin
            wr_addr[7:4] = a; wr_strb[3:2] = s; wr_data[63:32] = d;
        end else begin
            wr_addr[3:0] = a; wr_strb[1:0] = s; wr_data[31:0] = d;
        end
    endtask

    task automatic set_rd(input logic id, input logic [3:0] a);
        if (id) rd_addr[7:4] = a;
        else    rd_addr[3:0] = a;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_valid = 2'b00; rd_valid = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_cmd(input cmd_t c, input string tag);
        bit got = 0;
        int hs = 0;
        logic [31:0] act_d, exp_d;
        beats.delete();
        rsps.delete();
        @(negedge clk);
        if (c.is_wr) begin
            set_wr(c.id, c.addr, c.strb, c.data);
            wr_valid[c.id] = 1'b1;
        end else begin
            set_rd(c.id, c.addr);
            rd_valid[c.id] = 1'b1;
        end
        for (int n = 0; n < 16; n++) begin
            #1;
            if (c.is_wr ? wr_ready[c.id] : rd_ready[c.id]) begin
                got = 1;
                hs = cyc;
            end
            @(negedge clk);
            if (got) break;
        end
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        repeat (4) @(negedge clk);
        check({tag, "_handshake"}, 64'(got), 64'd1);
        if (c.is_wr) begin
            check({tag, "_nbeats"}, 64'(beats.size()), 64'(c.n_beats));
            if (c.n_beats == 1 && beats.size() == 1) begin
                act_d = (c.e_strb == 2'b11) ? beats[0].data : {16'h0, beats[0].data[15:0]};
                exp_d = (c.e_strb == 2'b11) ? c.e_data : {16'h0, c.e_data[15:0]};
                check({tag, "_beat"}, 64'({beats[0].addr, beats[0].strb, act_d}),
                      64'({c.e_addr, c.e_strb, exp_d}));
                check({tag, "_beat_latency"}, 64'(beats[0].cyc - hs), 64'd1);
            end
        end else begin
            check({tag, "_nrsp"}, 64'(rsps.size()), 64'd1);
            if (rsps.size() == 1) begin
                check({tag, "_rsp"}, 64'({rsps[0].id, rsps[0].data}), 64'({c.id, c.e_rd}));
                check({tag, "_rsp_latency"}, 64'(rsps[0].cyc - hs), 64'd2);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t, required to finish before it", $time);
        $fatal(1);
    end

    initial begin
        wr_valid = 2'b00; rd_valid = 2'b00;
        wr_addr = 8'h0; rd_addr = 8'h0; wr_strb = 4'h0; wr_data = 64'h0;

        tbl[0]  = mk_wr(1'b0, 4'd3,  2'b11, 32'hBEEF_1234, 1, 4'd3,  2'b11, 32'hBEEF_1234);
        tbl[1]  = mk_rd(1'b0, 4'd3,  16'h1234);
        tbl[2]  = mk_rd(1'b0, 4'd4,  16'hBEEF);
        tbl[3]  = mk_wr(1'b1, 4'd10, 2'b01, 32'h0000_CAFE, 1, 4'd10, 2'b01, 32'h0000_CAFE);
        tbl[4]  = mk_wr(1'b0, 4'd15, 2'b10, 32'h1234_5678, 1, 4'd0,  2'b01, 32'h0000_1234);
        tbl[5]  = mk_rd(1'b1, 4'd0,  16'h1234);
        tbl[6]  = mk_wr(1'b0, 4'd7,  2'b11, 32'h0000_7777, 1, 4'd7,  2'b11, 32'h0000_7777);
        tbl[7]  = mk_rd(1'b1, 4'd7,  16'h7777);
        tbl[8]  = mk_wr(1'b1, 4'd15, 2'b01, 32'h0000_9999, 1, 4'd15, 2'b01, 32'h0000_9999);
        tbl[9]  = mk_rd(1'b0, 4'd15, 16'h9999);
        tbl[10] = mk_rd(1'b1, 4'd10, 16'hCAFE);
        tbl[11] = mk_rd(1'b0, 4'd8,  16'h0000);

`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec(), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_idle_outputs", out_vec(), 64'h0);
        wr_valid = 2'b11; rd_valid = 2'b11;
        #1;
        check("reset_ptr_a", 64'({wr_ready, rd_ready}), 64'h5);
        wr_valid = 2'b00; rd_valid = 2'b00;

        // reset while the split beat is pending
        @(negedge clk);
        set_wr(1'b0, 4'd15, 2'b11, 32'h7654_3210);
        wr_valid = 2'b01;
        #1;
        check("split_rst_ready", 64'(wr_ready), 64'h1);
        @(negedge clk);
        wr_valid = 2'b00;
        #1;
        check("split_rst_beat1", 64'({ram_wr_en, ram_waddr, ram_wr_strb}), 64'({1'b1, 4'd15, 2'b01}));
        rst_n = 1'b0;
        #1;
        check("split_rst_outputs", out_vec(), 64'h0);
        beats.delete();
        rsps.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("split_rst_no_beat2", 64'(beats.size()), 64'd0);
        check("split_rst_no_rsp", 64'(rsps.size()), 64'd0);
        run_cmd(mk_rd(1'b0, 4'd0,  16'h0000), "split_rst_rd0");
        run_cmd(mk_rd(1'b0, 4'd15, 16'h0000), "split_rst_rd15");

        for (int i = 0; i < 12; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

        // B split write, with A presenting a zero-strobe write during W_SPLIT
        beats.delete();
        @(negedge clk);
        set_wr(1'b1, 4'd15, 2'b11, 32'hAAAA_5555);
        wr_valid = 2'b10;
        #1;
        check("split_ready_b", 64'(wr_ready), 64'h2);
        @(negedge clk);
        set_wr(1'b0, 4'd7, 2'b00, 32'hFFFF_FFFF);
        wr_valid = 2'b01;
        #1;
        check("split_ready_zero", 64'(wr_ready), 64'h0);
        @(negedge clk);
        #1;
        check("split_after_ready", 64'(wr_ready), 64'h1);
        @(negedge clk);
        wr_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("split_nbeats", 64'(beats.size()), 64'd2);
        if (beats.size() == 2) begin
            check("split_beat1", 64'({beats[0].addr, beats[0].strb, beats[0].data[15:0]}),
                  64'({4'd15, 2'b01, 16'h5555}));
            check("split_beat2", 64'({beats[1].addr, beats[1].strb, beats[1].data[15:0]}),
                  64'({4'd0, 2'b01, 16'hAAAA}));
            check("split_beat_gap", 64'(beats[1].cyc - beats[0].cyc), 64'd1);
        end
        run_cmd(mk_rd(1'b1, 4'd15, 16'h5555), "split_rd15");
        run_cmd(mk_rd(1'b0, 4'd0,  16'hAAAA), "split_rd0");
        run_cmd(mk_rd(1'b1, 4'd7,  16'h7777), "strb0_rd7");

        // same-cycle read and write of one address returns old data
        rsps.delete();
        @(negedge clk);
        set_wr(1'b0, 4'd5, 2'b01, 32'h0000_0001);
        wr_valid = 2'b01;
        #1;
        check("rw_wr1_ready", 64'(wr_ready), 64'h1);
        @(negedge clk);
        set_wr(1'b0, 4'd5, 2'b01, 32'h0000_0002);
        set_rd(1'b1, 4'd5);
        rd_valid = 2'b10;
        #1;
        check("rw_same_cycle_ready", 64'({wr_ready, rd_ready}), 64'h6);
        @(negedge clk);
        wr_valid = 2'b00; rd_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("rw_nrsp", 64'(rsps.size()), 64'd1);
        if (rsps.size() == 1) check("rw_old_data", 64'({rsps[0].id, rsps[0].data}), 64'({1'b1, 16'h0001}));
        run_cmd(mk_rd(1'b1, 4'd5, 16'h0002), "rw_new_data");

        // contention: both requesters hold valid for four cycles
        do_reset();
        beats.delete();
        set_wr(1'b0, 4'd1, 2'b01, 32'h0000_1111);
        set_wr(1'b1, 4'd2, 2'b01, 32'h0000_2222);
        wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("wr_contend_gnt%0d", i), 64'(wr_ready), 64'(exp_g[i]));
            @(negedge clk);
        end
        wr_valid = 2'b00;
        repeat (3) @(negedge clk);
        check("wr_contend_nbeats", 64'(beats.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < beats.size())
                check($sformatf("wr_contend_addr%0d", i), 64'(beats[i].addr),
                      (exp_g[i] == 2'b01) ? 64'd1 : 64'd2);
        end

        rsps.delete();
        set_rd(1'b0, 4'd1);
        set_rd(1'b1, 4'd2);
        rd_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rd_contend_gnt%0d", i), 64'(rd_ready), 64'(exp_g[i]));
            @(negedge clk);
        end
        rd_valid = 2'b00;
        repeat (4) @(negedge clk);
        check("rd_contend_nrsp", 64'(rsps.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rsps.size()) begin
                check($sformatf("rd_contend_rsp%0d", i), 64'({rsps[i].id, rsps[i].data}),
                      (exp_g[i] == 2'b01) ? 64'({1'b0, 16'h1111}) : 64'({1'b1, 16'h2222}));
                check($sformatf("rd_contend_cyc%0d", i), 64'(rsps[i].cyc - rsps[0].cyc), 64'(i));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
